mem_access_ctrl: RTL and testbench

Sequencing controller between the CPU load/store port and the two data memories: the 1 kB internal RAM mapped at 0x2B10–0x2F0F and the external memory bus. It decodes each access, drives the internal RAM directly, runs a req/ack handshake for external accesses, and stalls the CPU until each access completes. An optional timeout aborts external accesses that never acknowledge.

---
 rtl/mem_access_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences CPU loads and stores between the internal RAM
// window [INT_BASE, INT_TOP] and the external req/ack memory bus, and stalls
// the CPU until each access has completed.
// Optional build macro MEMCTRL_TIMEOUT_EN adds an abort of external accesses
// that are not acknowledged within TIMEOUT cycles, reported on bus_err.
module mem_access_ctrl #(
  parameter logic [31:0] INT_BASE = 32'h2B10,
  parameter logic [31:0] INT_TOP  = 32'h2F0F,
  parameter int          TIMEOUT  = 16
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        re,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        bus_err,
  output logic        int_cs,
  output logic        int_we,
  output logic [9:0]  int_addr,
  output logic [31:0] int_wdata,
  input  logic [31:0] int_rdata,
  output logic        ext_req,
  output logic        ext_we,
  output logic [31:0] ext_addr,
  output logic [31:0] ext_wdata,
  input  logic [31:0] ext_rdata,
  input  logic        ext_ack
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INT_RD   = 2'd1,
    EXT_WAIT = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Only the low 10 bits of the offset matter; subtracting the low bits of
  // the base gives the same result modulo 1 kB without a 32-bit subtractor.
  localparam logic [9:0] BASE_LO = INT_BASE[9:0];

  state_t      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ext_req_q, ext_req_d;
  logic        ext_we_q, ext_we_d;
  logic [31:0] ext_addr_q, ext_addr_d;
  logic [31:0] ext_wdata_q, ext_wdata_d;
  logic        hit;

`ifdef MEMCTRL_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       bus_err_q, bus_err_d;
`endif

  // Address decode and pass-through of the internal RAM address/data.
  always_comb begin
    hit       = (addr >= INT_BASE) && (addr <= INT_TOP);
    int_addr  = addr[9:0] - BASE_LO;
    int_wdata = wdata;
  end

  // Next-state, stall and internal RAM strobe logic.
  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    ext_req_d   = ext_req_q;
    ext_we_d    = ext_we_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    stall       = 1'b0;
    int_cs      = 1'b0;
    int_we      = 1'b0;
`ifdef MEMCTRL_TIMEOUT_EN
    cnt_d       = cnt_q;
    bus_err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (we && hit) begin
          int_cs = 1'b1;
          int_we = 1'b1;
        end else if (re && hit) begin
          int_cs  = 1'b1;
          stall   = 1'b1;
          state_d = INT_RD;
        end else if (re || we) begin
          stall       = 1'b1;
          ext_addr_d  = addr;
          ext_wdata_d = wdata;
          ext_we_d    = we;
          ext_req_d   = 1'b1;
          state_d     = EXT_WAIT;
`ifdef MEMCTRL_TIMEOUT_EN
          cnt_d       = 8'd0;
`endif
        end
      end
      INT_RD: begin
        stall   = 1'b1;
        rdata_d = int_rdata;
        state_d = DONE;
      end
      EXT_WAIT: begin
        stall = 1'b1;
        if (ext_ack) begin
          ext_req_d = 1'b0;
          if (!ext_we_q) begin
            rdata_d = ext_rdata;
          end
          state_d = DONE;
        end
`ifdef MEMCTRL_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          ext_req_d = 1'b0;
          if (!ext_we_q) begin
            rdata_d = 32'h0;
          end
          bus_err_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rdata_q     <= 32'h0;
      ext_req_q   <= 1'b0;
      ext_we_q    <= 1'b0;
      ext_addr_q  <= 32'h0;
      ext_wdata_q <= 32'h0;
`ifdef MEMCTRL_TIMEOUT_EN
      cnt_q       <= 8'd0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      ext_req_q   <= ext_req_d;
      ext_we_q    <= ext_we_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
`ifdef MEMCTRL_TIMEOUT_EN
      cnt_q       <= cnt_d;
      bus_err_q   <= bus_err_d;
`endif
    end
  end

  assign rdata     = rdata_q;
  assign ext_req   = ext_req_q;
  assign ext_we    = ext_we_q;
  assign ext_addr  = ext_addr_q;
  assign ext_wdata = ext_wdata_q;

`ifdef MEMCTRL_TIMEOUT_EN
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed transactions against mem_access_ctrl with a
// scoreboard queue of expected completions and a negedge monitor.
module tb_mem_access_ctrl;

  logic        CLK = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [31:0] rdata;
  logic        stall;
  logic        bus_err;
  logic        int_cs;
  logic        int_we;
  logic [9:0]  int_addr;
  logic [31:0] int_wdata;
  logic [31:0] int_rdata = 32'h0;
  logic        ext_req;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic [31:0] ext_rdata = 32'h0;
  logic        ext_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    int          stalls;
    int          extCycles;
    logic [31:0] extAddr;
    logic        extWe;
    logic [31:0] extWdata;
    logic        intWr;
    logic [9:0]  intAddr;
    logic        berr;
  } exp_t;

  exp_t expQ[$];

  logic [31:0] mem [256];

  mem_access_ctrl dut (
    .CLK       (CLK),
    .rst       (rst),
    .addr      (addr),
    .wdata     (wdata),
    .re        (re),
    .we        (we),
    .rdata     (rdata),
    .stall     (stall),
    .bus_err   (bus_err),
    .int_cs    (int_cs),
    .int_we    (int_we),
    .int_addr  (int_addr),
    .int_wdata (int_wdata),
    .int_rdata (int_rdata),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_rdata (ext_rdata),
    .ext_ack   (ext_ack)
  );

  always #5 CLK = ~CLK;

  // Internal RAM model: synchronous read, data valid the cycle after int_cs.
  always @(posedge CLK) begin
    if (int_cs) begin
      if (int_we) mem[int_addr[9:2]] <= int_wdata;
      else        int_rdata <= mem[int_addr[9:2]];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: accumulate what the DUT did during a transaction, compare when it completes.
  initial begin
    int          stallCnt = 0;
    int          extCnt = 0;
    logic [31:0] extAddrSeen = 0;
    logic        extWeSeen = 0;
    logic [31:0] extWdataSeen = 0;
    logic        intWrSeen = 0;
    logic [9:0]  intAddrSeen = 0;
    logic        berrSeen = 0;
    exp_t        e;
    forever begin
      @(negedge CLK);
      if (!rst) begin
        stallCnt = 0; extCnt = 0; intWrSeen = 0; berrSeen = 0;
      end else begin
        if (stall) stallCnt++;
        if (ext_req) begin
          extCnt++;
          extAddrSeen = ext_addr;
          extWeSeen = ext_we;
          extWdataSeen = ext_wdata;
        end
        if (int_cs && int_we) begin
          intWrSeen = 1'b1;
          intAddrSeen = int_addr;
        end
        if (bus_err) berrSeen = 1'b1;
        if ((re || we) && !stall) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected completion: got addr %h, expected none", addr);
          end else begin
            e = expQ.pop_front();
            checkOutput("rdata", rdata, e.rdata);
            checkOutput("stall_cycles", 32'(stallCnt), 32'(e.stalls));
            checkOutput("ext_req_cycles", 32'(extCnt), 32'(e.extCycles));
            if (e.extCycles > 0) begin
              checkOutput("ext_addr", extAddrSeen, e.extAddr);
              checkOutput("ext_we", {31'h0, extWeSeen}, {31'h0, e.extWe});
              if (e.extWe) checkOutput("ext_wdata", extWdataSeen, e.extWdata);
            end
            checkOutput("int_write", {31'h0, intWrSeen}, {31'h0, e.intWr});
            if (e.intWr) checkOutput("int_addr", {22'h0, intAddrSeen}, {22'h0, e.intAddr});
            checkOutput("bus_err", {31'h0, berrSeen}, {31'h0, e.berr});
          end
          stallCnt = 0; extCnt = 0; intWrSeen = 0; berrSeen = 0;
        end
      end
    end
  end

  // Issue one request at posedge+1, optionally acknowledge it after ackDelay cycles,
  // wait (bounded) for completion, then drop the request in the following IDLE cycle.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic r,
                               input logic w, input int ackDelay, input logic [31:0] ackData,
                               input exp_t e);
    bit done = 0;
    expQ.push_back(e);
    addr = a; wdata = d; re = r; we = w;
    if (ackDelay > 0) begin
      repeat (ackDelay) @(posedge CLK);
      #1 ext_ack = 1'b1; ext_rdata = ackData;
      @(posedge CLK);
      #1 ext_ack = 1'b0; ext_rdata = 32'h0;
    end
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge CLK);
      if (!stall) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL completion_timeout: got stall stuck at addr %h, expected completion", a);
    end
    @(posedge CLK);
    #1 re = 1'b0; we = 1'b0;
  endtask

  function automatic exp_t mk(input logic [31:0] rd, input int st, input int ec,
                              input logic [31:0] ea, input logic ew, input logic [31:0] ed,
                              input logic iw, input logic [9:0] ia, input logic be);
    exp_t e;
    e.rdata = rd; e.stalls = st; e.extCycles = ec; e.extAddr = ea; e.extWe = ew;
    e.extWdata = ed; e.intWr = iw; e.intAddr = ia; e.berr = be;
    return e;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[255] = 32'h12345678;

    #12;
    checkOutput("reset_rdata", rdata, 32'h0);
    checkOutput("reset_stall", {31'h0, stall}, 32'h0);
    checkOutput("reset_ext_req", {31'h0, ext_req}, 32'h0);
    checkOutput("reset_ext_we", {31'h0, ext_we}, 32'h0);
    checkOutput("reset_ext_addr", ext_addr, 32'h0);
    checkOutput("reset_ext_wdata", ext_wdata, 32'h0);
    checkOutput("reset_int_cs", {31'h0, int_cs}, 32'h0);
    checkOutput("reset_bus_err", {31'h0, bus_err}, 32'h0);
    @(negedge CLK) rst = 1'b1;
    @(posedge CLK); #1;

    applyStimulus(32'h2B10, 32'hCAFE0001, 0, 1, 0, 0, mk(32'h0, 0, 0, 0, 0, 0, 1, 10'h000, 0));
    applyStimulus(32'h2F0C, 32'h0, 1, 0, 0, 0, mk(32'h12345678, 2, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(32'h2B10, 32'h0, 1, 0, 0, 0, mk(32'hCAFE0001, 2, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(32'h2F10, 32'h0, 1, 0, 3, 32'hA5A5A5A5,
                  mk(32'hA5A5A5A5, 4, 3, 32'h2F10, 0, 0, 0, 0, 0));
    applyStimulus(32'h0, 32'hDEADBEEF, 1, 1, 1, 32'h99999999,
                  mk(32'hA5A5A5A5, 2, 1, 32'h0, 1, 32'hDEADBEEF, 0, 0, 0));
    applyStimulus(32'h2F0F, 32'h0BADF00D, 0, 1, 0, 0, mk(32'hA5A5A5A5, 0, 0, 0, 0, 0, 1, 10'h3FF, 0));
    applyStimulus(32'h2F0C, 32'h0, 1, 0, 0, 0, mk(32'h0BADF00D, 2, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(32'h2B0F, 32'h0, 1, 0, 2, 32'h11111111,
                  mk(32'h11111111, 3, 2, 32'h2B0F, 0, 0, 0, 0, 0));
    applyStimulus(32'h2F10, 32'h22222222, 0, 1, 1, 32'h33333333,
                  mk(32'h11111111, 2, 1, 32'h2F10, 1, 32'h22222222, 0, 0, 0));

    ext_ack = 1'b1; ext_rdata = 32'h44444444;
    @(posedge CLK);
    #1 ext_ack = 1'b0; ext_rdata = 32'h0;
    checkOutput("idle_ack_ext_req", {31'h0, ext_req}, 32'h0);
    checkOutput("idle_ack_rdata", rdata, 32'h11111111);

    addr = 32'h3000; re = 1'b1;
    repeat (3) @(posedge CLK);
    #1 rst = 1'b0; re = 1'b0;
    #1;
    checkOutput("rst_mid_ext_req", {31'h0, ext_req}, 32'h0);
    checkOutput("rst_mid_stall", {31'h0, stall}, 32'h0);
    checkOutput("rst_mid_rdata", rdata, 32'h0);
    @(negedge CLK) rst = 1'b1;
    @(posedge CLK); #1;
    applyStimulus(32'h2B10, 32'h0, 1, 0, 0, 0, mk(32'hCAFE0001, 2, 0, 0, 0, 0, 0, 0, 0));

`ifdef MEMCTRL_TIMEOUT_EN
    applyStimulus(32'h10000, 32'h0, 1, 0, 0, 0, mk(32'h0, 17, 16, 32'h10000, 0, 0, 0, 0, 1));
    checkOutput("timeout_ext_req", {31'h0, ext_req}, 32'h0);
`endif

    repeat (3) @(posedge CLK);
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
